// File: rtl/sakebi_crc32_checker_if.sv
// Byte-wide AXI-Stream bundle used on both sides of the CRC32 checker.
// Handshake: a beat transfers on every rising edge where TVALID=1; there is no TREADY, so the sink must accept every valid beat.
interface sakebi_crc32_checker_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  TVALID;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;

  modport master (output TVALID, output TDATA, output TLAST);
  modport slave  (input  TVALID, input  TDATA, input  TLAST);
endinterface

// File: rtl/sakebi_crc32_checker.sv
// Receive-side Ethernet FCS checker: strips the 4-byte trailing FCS through a delay line,
// forwards the payload one cycle later, and pulses a per-frame CRC/runt status.
module sakebi_crc32_checker #(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] CRC_INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] CRC_RESIDUE = 32'hDEBB20E3
) (
  input  logic                    i_axis_ACLK,
  input  logic                    i_axis_ARESETn,
  sakebi_crc32_checker_if.slave   i_axis,
  sakebi_crc32_checker_if.master  o_axis,
  output logic                    o_crc_valid,
  output logic                    o_crc_ok,
  output logic                    o_runt
);

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  // Reflected CRC-32, one byte per call, LSB of the byte enters first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [DATA_WIDTH-1:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  logic [31:0]           crc_q, crc_d, crc_next;
  logic [2:0]            fill_q, fill_d;
  logic [DATA_WIDTH-1:0] dly_q [4];
  logic [DATA_WIDTH-1:0] dly_d [4];
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  crc_valid_q, crc_valid_d;
  logic                  crc_ok_q, crc_ok_d;
  logic                  runt_q, runt_d;
  logic                  full;

  assign full = (fill_q == 3'd4);

  always_comb begin
    crc_next    = crc32_byte(crc_q, i_axis.TDATA);
    crc_d       = crc_q;
    fill_d      = fill_q;
    dly_d       = dly_q;
    tvalid_d    = 1'b0;
    tdata_d     = '0;
    tlast_d     = 1'b0;
    crc_valid_d = 1'b0;
    crc_ok_d    = crc_ok_q;
    runt_d      = 1'b0;

    if (i_axis.TVALID) begin
      dly_d[0] = i_axis.TDATA;
      for (int i = 1; i < 4; i++) begin
        dly_d[i] = dly_q[i-1];
      end

      // Once four bytes are buffered, each new byte proves the oldest one is payload.
      if (full) begin
        tvalid_d = 1'b1;
        tdata_d  = dly_q[3];
        tlast_d  = i_axis.TLAST;
      end

      if (i_axis.TLAST) begin
        crc_valid_d = 1'b1;
        crc_d       = CRC_INIT;
        fill_d      = 3'd0;
        if (full) begin
          crc_ok_d = (crc_next == CRC_RESIDUE);
        end else begin
          crc_ok_d = 1'b0;
          runt_d   = 1'b1;
        end
      end else begin
        crc_d = crc_next;
        if (!full) begin
          fill_d = fill_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge i_axis_ACLK or negedge i_axis_ARESETn) begin
    if (!i_axis_ARESETn) begin
      crc_q       <= CRC_INIT;
      fill_q      <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        dly_q[i] <= '0;
      end
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
      crc_valid_q <= 1'b0;
      crc_ok_q    <= 1'b0;
      runt_q      <= 1'b0;
    end else begin
      crc_q       <= crc_d;
      fill_q      <= fill_d;
      dly_q       <= dly_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
      crc_valid_q <= crc_valid_d;
      crc_ok_q    <= crc_ok_d;
      runt_q      <= runt_d;
    end
  end

  assign o_axis.TVALID = tvalid_q;
  assign o_axis.TDATA  = tdata_q;
  assign o_axis.TLAST  = tlast_q;
  assign o_crc_valid   = crc_valid_q;
  assign o_crc_ok      = crc_ok_q;
  assign o_runt        = runt_q;

endmodule

// File: doc/sakebi_crc32_checker.md
Name: sakebi_crc32_checker

Overview:
Receive-side counterpart of the CRC32 generator wrapper. It takes an 8-bit AXI-Stream frame whose last 4 beats carry the Ethernet FCS, transmitted LSB-first. It forwards the payload with the FCS stripped and reports per frame whether the CRC32 is good. It sits between the byte-wide RX path and the frame consumer. There is no backpressure: the upstream source has no TREADY.

Parameters:
DATA_WIDTH, 8, stream byte width; only 8 is supported.
CRC_INIT, 32'hFFFFFFFF, CRC register value at the start of each frame.
CRC_RESIDUE, 32'hDEBB20E3, un-inverted register value after data+FCS that indicates a good frame.

Ports:
i_axis_ACLK  in  1  clock, all logic on rising edge
i_axis_ARESETn  in  1  reset, asynchronous, active-low
i_axis_TVALID  in  1  input beat valid; every valid beat is accepted
i_axis_TDATA  in  DATA_WIDTH  input byte
i_axis_TLAST  in  1  marks last beat of frame (last FCS byte)
o_axis_TVALID  out  1  payload byte valid
o_axis_TDATA  out  DATA_WIDTH  payload byte
o_axis_TLAST  out  1  last payload byte of frame
o_crc_valid  out  1  one-cycle pulse: frame status available
o_crc_ok  out  1  1 = CRC matched; qualified by o_crc_valid
o_runt  out  1  1 = frame had fewer than 5 beats; qualified by o_crc_valid

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - CRC register = CRC_INIT.
  - Fill count = 0.
  - 4-byte delay line is cleared.
- Reset asserted mid-frame discards the partial frame. No status pulse is produced for it.
- CRC definition: reflected CRC-32, polynomial 0xEDB88320, LSB-first per byte, one byte per accepted beat. The next-CRC function is combinational over the current register and the byte.
- Only beats with i_axis_TVALID=1 advance state. Bubbles hold all state, and outputs drop to 0 on bubble cycles (o_axis_TVALID, o_crc_valid).
- Delay line: a 4-entry shift register plus a fill count (0..4, saturating).
  - On an accepted beat with fill count = 4, the oldest byte is emitted. The output is registered: o_axis_TVALID=1 in the next cycle, with o_axis_TDATA = oldest byte.
  - The new byte is shifted in on every accepted beat.
  - Latency: the payload byte is emitted 1 cycle after the input beat that pushes it out, i.e. payload byte k appears after beat k+4 is accepted.
- End of frame (accepted beat with i_axis_TLAST=1):
  - If fill count = 4, the emitted byte carries o_axis_TLAST=1.
  - In the following cycle, o_crc_valid=1 and o_crc_ok = (next_crc == CRC_RESIDUE), where next_crc includes the TLAST byte.
  - The bytes remaining in the delay line are the FCS and are discarded.
  - o_crc_valid and o_axis_TLAST occur in the same cycle.
- Runt: TLAST arrives with fill count < 4 (frame of 1..4 beats).
  - No payload beats are emitted.
  - Next cycle: o_crc_valid=1, o_crc_ok=0, o_runt=1.
- After TLAST, the CRC register returns to CRC_INIT and the fill count returns to 0 in the same edge. A back-to-back frame starting on the very next cycle is handled without a gap.
- o_runt=0 and o_crc_ok hold their last value whenever o_crc_valid=0; consumers sample them only when o_crc_valid=1.
- A 5-beat frame is valid: 1 payload byte, emitted with o_axis_TLAST=1.

Test Plan:
1. Good frame: bytes 31 32 33 34 35 36 37 38 39 then FCS 26 39 F4 CB (CRC32("123456789")=0xCBF43926), TLAST on CB, continuous TVALID.
   -> 9 output bytes 31..39, o_axis_TLAST with 39, o_crc_valid=1, o_crc_ok=1, o_runt=0 in the same cycle.
2. Corrupt FCS: same frame, last byte CA.
   -> identical payload output, o_crc_ok=0.
   Separately, flip payload byte 35->34 with the original FCS.
   -> o_crc_ok=0.
3. Bubbles: scenario 1 with TVALID deasserted every other cycle.
   -> same payload sequence and status, no output during bubbles, status 1 cycle after the TLAST beat.
4. Runt and minimum frame:
   - 3-beat frame 12 34 56 with TLAST -> no o_axis_TVALID, o_crc_valid=1, o_runt=1, o_crc_ok=0.
   - 5-beat frame -> exactly 1 payload beat, which carries TLAST.
5. Back-to-back: frame of scenario 1 immediately followed (no idle cycle) by its corrupt variant.
   -> two status pulses, ok=1 then ok=0, 18 payload bytes total.
6. Reset mid-frame: deassert i_axis_ARESETn after 6 beats of scenario 1 for 2 cycles, then send scenario 1 complete.
   -> outputs 0 during reset, no status for the aborted frame, one good status for the new frame.
